// File: rtl/fetch_unit.sv
// fetch_unit -- multicycle instruction-fetch stage.
//
// Owns the program counter, issues one instruction-memory read at a time and
// hands each fetched word, together with its PC, to decode over a
// valid/ready handshake. Execute may redirect the PC at any time; a redirect
// that arrives while a read is outstanding cannot cancel the read, so the
// returned word is dropped and fetch restarts at the redirect target.
//
// Configuration macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a non word-aligned target enters FAULT
//               (out_fault=1) and waits for an aligned redirect.
//   undefined : the low two bits of redirect_pc are cleared and fetch
//               proceeds; out_fault is tied low.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   mem_req         read request, held until mem_ack
//   mem_addr        read address, stable for the whole request
//   mem_ack         read completes this cycle, mem_rdata valid
//   mem_rdata       returned instruction word
//   out_valid       out_instr/out_pc valid to decode
//   out_ready       decode accepts this cycle
//   out_instr       fetched instruction
//   out_pc          address of out_instr (faulting target while in FAULT)
//   redirect_valid  load a new PC from execute
//   redirect_pc     redirect target
//   out_fault       misaligned-target fault indication

module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;
`endif

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] pend_pc, pend_next;
  logic              kill, kill_next;
  logic [DATA_W-1:0] instr_q, instr_next;
  logic [ADDR_W-1:0] opc_q, opc_next;

  // Redirect target as the fetch logic sees it. Without the trap, misaligned
  // targets are silently rounded down to a word boundary.
  logic [ADDR_W-1:0] redir_tgt;
  // Where fetch resumes when a discarded read finally completes: a redirect
  // in the same cycle overrides the one remembered in pend_pc.
  logic [ADDR_W-1:0] ack_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_tgt = redirect_pc;
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign redir_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
`endif

  assign ack_tgt = redirect_valid ? redir_tgt : pend_pc;

  // State and datapath registers; reset aborts any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
      kill    <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pend_pc <= pend_next;
      kill    <= kill_next;
      instr_q <= instr_next;
      opc_q   <= opc_next;
    end
  end

  // Next-state logic. A redirect during an outstanding read only records the
  // target and sets kill; the address stays put until mem_ack closes the
  // read, which keeps mem_addr stable for the memory.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    pend_next  = pend_pc;
    kill_next  = kill;
    instr_next = instr_q;
    opc_next   = opc_q;

    case (state)
      IDLE: begin
        state_next = FETCH;
        if (redirect_valid) begin
          pc_next = redir_tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (redir_tgt[1:0] != 2'b00) begin
            state_next = FAULT;
            opc_next   = redir_tgt;
          end
`endif
        end
      end

      FETCH: begin
        if (mem_ack) begin
          if (kill || redirect_valid) begin
            kill_next = 1'b0;
            pc_next   = ack_tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (ack_tgt[1:0] != 2'b00) begin
              state_next = FAULT;
              opc_next   = ack_tgt;
            end
`endif
          end else begin
            instr_next = mem_rdata;
            opc_next   = pc;
            pc_next    = pc + ADDR_W'(4);
            state_next = VALID;
          end
        end else if (redirect_valid) begin
          pend_next = redir_tgt;
          kill_next = 1'b1;
        end
      end

      VALID: begin
        // A redirect wins over holding; a simultaneous out_ready still
        // completes the transfer because decode loads on the handshake.
        if (redirect_valid) begin
          pc_next    = redir_tgt;
          state_next = FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (redir_tgt[1:0] != 2'b00) begin
            state_next = FAULT;
            opc_next   = redir_tgt;
          end
`endif
        end else if (out_ready) begin
          state_next = FETCH;
        end
      end

`ifdef FETCH_MISALIGN_TRAP_EN
      FAULT: begin
        if (redirect_valid) begin
          if (redir_tgt[1:0] == 2'b00) begin
            pc_next    = redir_tgt;
            state_next = FETCH;
          end else begin
            opc_next = redir_tgt;
          end
        end
      end
`endif

      default: state_next = IDLE;
    endcase
  end

  assign mem_req   = (state == FETCH);
  assign mem_addr  = pc;
  assign out_valid = (state == VALID);
  assign out_instr = instr_q;
  assign out_pc    = opc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign out_fault = (state == FAULT);
`else
  assign out_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// The bench plays instruction memory: every word it returns is a fixed
// function of the requested address, so any delivered out_instr can be
// predicted from out_pc. The reference model is transaction level: it only
// tracks the address the next fetch must use, updated by +4 after a delivered
// instruction or set to the redirect target when a fetch is redirected.

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_fault;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_pc;
  int          kind;
  int          nred;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_fault      (out_fault)
  );

  // Memory contents: a scrambled but deterministic function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] aligned(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] rand_tgt();
    return 32'h0040_0000 | ($urandom & 32'h0000_FFFC);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive all inputs, then advance to the next falling edge where outputs
  // are sampled.
  task automatic applyStimulus(input logic r, input logic ack, input logic [31:0] rdata,
                               input logic rdy, input logic rv, input logic [31:0] rpc);
    rst            = r;
    mem_ack        = ack;
    mem_rdata      = rdata;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  task automatic expectFetch(input string tag);
    checkFlag({tag, ".mem_req"}, mem_req, 1'b1);
    checkOutput({tag, ".mem_addr"}, mem_addr, exp_pc);
    checkFlag({tag, ".out_valid"}, out_valid, 1'b0);
  endtask

  task automatic expectValid(input string tag, input logic [31:0] pc);
    checkFlag({tag, ".out_valid"}, out_valid, 1'b1);
    checkOutput({tag, ".out_pc"}, out_pc, pc);
    checkOutput({tag, ".out_instr"}, out_instr, mem_word(pc));
    checkFlag({tag, ".mem_req"}, mem_req, 1'b0);
    checkFlag({tag, ".out_fault"}, out_fault, 1'b0);
  endtask

  task automatic expectIdle(input string tag);
    checkFlag({tag, ".mem_req"}, mem_req, 1'b0);
    checkFlag({tag, ".out_valid"}, out_valid, 1'b0);
    checkFlag({tag, ".out_fault"}, out_fault, 1'b0);
    checkOutput({tag, ".mem_addr"}, mem_addr, RESET_PC);
    checkOutput({tag, ".out_pc"}, out_pc, 32'h0);
    checkOutput({tag, ".out_instr"}, out_instr, 32'h0);
  endtask

  // One delivered instruction: wait_n stall cycles before mem_ack, hold_n
  // cycles of out_ready=0 in VALID, then a final cycle that either accepts
  // or redirects (with out_ready=rdy_last).
  task automatic fetchOne(input int wait_n, input int hold_n, input logic redir,
                          input logic rdy_last, input logic [31:0] tgt);
    logic [31:0] pc;
    pc = exp_pc;
    expectFetch("fetch");
    for (int i = 0; i < wait_n; i++) begin
      applyStimulus(1'b0, 1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b0, $urandom);
      expectFetch("wait");
    end
    applyStimulus(1'b0, 1'b1, mem_word(pc), 1'b0, 1'b0, $urandom);
    expectValid("deliver", pc);
    for (int i = 0; i < hold_n; i++) begin
      applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 1'b0, $urandom);
      expectValid("hold", pc);
    end
    if (redir) begin
      applyStimulus(1'b0, 1'b0, $urandom, rdy_last, 1'b1, tgt);
      exp_pc = aligned(tgt);
    end else begin
      applyStimulus(1'b0, 1'b0, $urandom, 1'b1, 1'b0, $urandom);
      exp_pc = pc + 32'd4;
    end
  endtask

  // A fetch that is redirected before or at its mem_ack: the word must be
  // dropped and fetch must resume at the most recent redirect target.
  task automatic killFetch(input int pre_n, input int n_redir, input int post_n,
                           input logic redir_at_ack, input logic [31:0] t1, input logic [31:0] t2);
    logic [31:0] base;
    logic [31:0] last;
    base = exp_pc;
    last = exp_pc;
    expectFetch("kill.start");
    for (int i = 0; i < pre_n; i++) begin
      applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 1'b0, $urandom);
      expectFetch("kill.pre");
    end
    for (int r = 0; r < n_redir; r++) begin
      last = (r == 0) ? t1 : t2;
      applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 1'b1, last);
      expectFetch("kill.redir");
    end
    for (int i = 0; i < post_n; i++) begin
      applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 1'b0, $urandom);
      expectFetch("kill.post");
    end
    if (redir_at_ack) begin
      last = t2;
      applyStimulus(1'b0, 1'b1, mem_word(base), 1'b1, 1'b1, t2);
    end else begin
      applyStimulus(1'b0, 1'b1, mem_word(base), 1'b1, 1'b0, $urandom);
    end
    exp_pc = aligned(last);
    expectFetch("kill.resume");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state, then fetch begins one cycle after release.
    applyStimulus(1'b1, 1'b0, $urandom, 1'b0, 1'b0, $urandom);
    applyStimulus(1'b1, 1'b1, $urandom, 1'b1, 1'b0, $urandom);
    expectIdle("reset");
    exp_pc = RESET_PC;
    applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 1'b0, $urandom);
    expectFetch("first");

    // Zero-wait memory, decode always ready.
    fetchOne(0, 0, 1'b0, 1'b1, 32'h0);
    fetchOne(0, 0, 1'b0, 1'b1, 32'h0);
    fetchOne(0, 0, 1'b0, 1'b1, 32'h0);
    checkOutput("seq.addr", mem_addr, 32'h0040_000C);

    // Slow memory and stalled decode.
    fetchOne(3, 0, 1'b0, 1'b1, 32'h0);
    fetchOne(0, 5, 1'b0, 1'b1, 32'h0);

    // Redirects against outstanding reads.
    killFetch(2, 1, 1, 1'b0, 32'h0040_0100, 32'h0);
    checkOutput("kill1.addr", mem_addr, 32'h0040_0100);
    killFetch(1, 2, 1, 1'b0, 32'h0040_0100, 32'h0040_0200);
    checkOutput("kill2.addr", mem_addr, 32'h0040_0200);
    killFetch(1, 0, 0, 1'b1, 32'h0, 32'h0040_0180);

    // Redirect coincident with a completed transfer, then PC wrap.
    fetchOne(0, 0, 1'b1, 1'b1, 32'h0040_0400);
    checkOutput("redir_xfer.addr", mem_addr, 32'h0040_0400);
    fetchOne(0, 1, 1'b1, 1'b0, 32'hFFFF_FFFC);
    fetchOne(0, 0, 1'b0, 1'b1, 32'h0);
    checkOutput("wrap.addr", mem_addr, 32'h0000_0000);
    fetchOne(1, 0, 1'b0, 1'b1, 32'h0);

    // Misaligned redirect targets.
`ifdef FETCH_MISALIGN_TRAP_EN
    expectFetch("mis.fetch");
    applyStimulus(1'b0, 1'b1, mem_word(exp_pc), 1'b0, 1'b0, $urandom);
    expectValid("mis.valid", exp_pc);
    applyStimulus(1'b0, 1'b0, $urandom, 1'b1, 1'b1, 32'h0040_0102);
    checkFlag("fault.out_fault", out_fault, 1'b1);
    checkFlag("fault.out_valid", out_valid, 1'b0);
    checkFlag("fault.mem_req", mem_req, 1'b0);
    checkOutput("fault.out_pc", out_pc, 32'h0040_0102);
    applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b0, $urandom);
    checkFlag("fault.hold", out_fault, 1'b1);
    applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 1'b1, 32'h0040_0106);
    checkFlag("fault.mis2", out_fault, 1'b1);
    checkOutput("fault.mis2_pc", out_pc, 32'h0040_0106);
    applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 1'b1, 32'h0040_0104);
    exp_pc = 32'h0040_0104;
    checkFlag("fault.exit", out_fault, 1'b0);
    expectFetch("fault.exit");
    applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 1'b1, 32'h0040_0203);
    expectFetch("fault.kill");
    applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 1'b0, $urandom);
    checkFlag("fault.ack", out_fault, 1'b1);
    checkOutput("fault.ack_pc", out_pc, 32'h0040_0203);
    checkFlag("fault.ack_req", mem_req, 1'b0);
    applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 1'b1, 32'h0040_0300);
    exp_pc = 32'h0040_0300;
    expectFetch("fault.exit2");
`else
    fetchOne(0, 0, 1'b1, 1'b1, 32'h0040_0102);
    checkFlag("mis.out_fault", out_fault, 1'b0);
    checkOutput("mis.addr", mem_addr, 32'h0040_0100);
    killFetch(0, 1, 0, 1'b0, 32'h0040_0203, 32'h0);
    checkOutput("mis_kill.addr", mem_addr, 32'h0040_0200);
    checkFlag("mis_kill.out_fault", out_fault, 1'b0);
`endif
    fetchOne(0, 0, 1'b0, 1'b1, 32'h0);

    // Reset mid-request; the late ack after release must be ignored.
    expectFetch("midrst");
    applyStimulus(1'b1, 1'b0, $urandom, 1'b0, 1'b0, $urandom);
    expectIdle("midrst.idle");
    applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b0, $urandom);
    exp_pc = RESET_PC;
    expectFetch("midrst.restart");
    checkOutput("midrst.out_pc", out_pc, 32'h0);

    // Randomised traffic against the transaction-level model.
    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0, 1: fetchOne(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b1, 32'h0);
        2:    fetchOne(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1,
                       1'($urandom_range(0, 1)), rand_tgt());
        default: begin
          nred = int'($urandom_range(0, 2));
          killFetch(int'($urandom_range(0, 2)), nred, int'($urandom_range(0, 2)),
                    (nred == 0) ? 1'b1 : 1'($urandom_range(0, 1)), rand_tgt(), rand_tgt());
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Multicycle instruction-fetch stage; owns the program counter and drives the instruction-memory handshake.
- Delivers each fetched word, with its PC, to decode through a valid/ready handshake. The downstream instruction and PC registers load on out_valid && out_ready.
- Accepts a redirect (branch/jump target) from execute at any time.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction word width
RESET_PC, 32'h0040_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
mem_req  out  1  instruction memory read request
mem_addr  out  ADDR_W  read address, held stable while mem_req=1 until mem_ack
mem_ack  in  1  memory returns mem_rdata this cycle; ends the request
mem_rdata  in  DATA_W  instruction word, valid when mem_ack=1
out_valid  out  1  out_instr/out_pc valid to decode
out_ready  in  1  decode accepts this cycle
out_instr  out  DATA_W  fetched instruction
out_pc  out  ADDR_W  address of out_instr
redirect_valid  in  1  load new PC (taken branch/jump)
redirect_pc  in  ADDR_W  redirect target
out_fault  out  1  misaligned-target fault (see Optional Feature)

Behaviour:
- rst=1 at an edge: state=IDLE, pc=RESET_PC, kill=0, out_instr=0, out_pc=0. Outputs during IDLE: mem_req=0, out_valid=0, out_fault=0, mem_addr=pc.
- rst sampled high mid-request aborts it. Any late mem_ack is ignored in IDLE.
- IDLE -> FETCH on first edge with rst=0. mem_req therefore rises one cycle after reset release.
- FETCH: mem_req=1, mem_addr=pc. mem_addr does not change while awaiting mem_ack, even on redirect.
- FETCH, mem_ack=1, kill=0, redirect_valid=0:
  - out_instr<=mem_rdata, out_pc<=pc, pc<=pc+4 (mod 2^ADDR_W, wraps silently), go VALID.
- FETCH, mem_ack=0, redirect_valid=1: pend_pc<=redirect_pc, kill<=1, stay FETCH with the same address.
- FETCH, mem_ack=1 with kill=1 or redirect_valid=1: discard mem_rdata, kill<=0, stay FETCH.
  - New pc = redirect_pc if redirect_valid=1 this cycle, else pend_pc.
  - mem_req stays high; mem_addr shows the new pc next cycle.
- Multiple redirects while kill=1: the latest redirect_pc wins.
- VALID: out_valid=1, out_instr/out_pc stable, mem_req=0.
  - out_ready=1: transfer done, go FETCH next cycle.
  - redirect_valid=1: pc<=redirect_pc, go FETCH. If out_ready=1 the same cycle, the transfer still counts as done.
  - Neither: hold.
- Latency: mem_ack at edge N means out_valid=1 in cycle N+1. Best-case throughput is one instruction per 2 cycles (zero-wait memory).
- out_valid never drops without a transfer or a redirect.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 enters state FAULT instead of fetching, with out_pc<=redirect_pc.
  - FAULT drives out_fault=1, out_valid=0, mem_req=0.
  - FAULT leaves only on an aligned redirect (go FETCH at that pc) or on rst. A misaligned redirect in FAULT updates out_pc and stays in FAULT.
  - A misaligned redirect during an outstanding request sets kill. The fault is entered when mem_ack arrives.
- Undefined: redirect_pc[1:0] is forced to 2'b00 and fetch proceeds. out_fault is tied 0 and the FAULT state does not exist.

Test Plan:
- Reset then zero-wait memory, out_ready=1 -> mem_addr sequence 0x00400000, 0x00400004, 0x00400008; out_valid every 2nd cycle; out_pc matches.
- mem_ack delayed 3 cycles -> mem_req held 4 cycles, mem_addr unchanged; out_instr=mem_rdata at ack; pc advances by exactly 4.
- out_ready=0 for 5 cycles in VALID -> out_valid, out_instr, out_pc stable; mem_req=0; no extra fetch.
- Redirect to 0x00400100 one cycle before a delayed ack -> returned word discarded (no out_valid); next mem_addr=0x00400100. A second redirect to 0x00400200 before the ack -> next fetch at 0x00400200.
- Redirect coincident with out_valid&&out_ready -> transfer counted; next mem_addr=redirect_pc. With pc=0xFFFFFFFC and no redirect -> next fetch at 0x00000000.
- With FETCH_MISALIGN_TRAP_EN: redirect to 0x00400102 -> out_fault=1, out_pc=0x00400102, mem_req=0; aligned redirect to 0x00400104 -> out_fault=0, fetch at 0x00400104. Without the macro: same stimulus -> fetch at 0x00400100, out_fault=0.
